// File: rtl/fir_seq_pkg.sv
// Shared types and default constants for the FIR band-filter sequencer.
package fir_seq_pkg;

  // Default datapath geometry
  localparam int unsigned NUM_TAPS = 1021;
  localparam int unsigned Q_DEPTH  = 1536;
  localparam int unsigned ADDR_W   = 11;
  localparam int unsigned COEF_W   = 10;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/fir_rd_ptr.sv
// Modular read-pointer counter for the circular sample queue: load, increment, wrap at Q_DEPTH.
module fir_rd_ptr #(
  parameter int unsigned Q_DEPTH = fir_seq_pkg::Q_DEPTH,
  parameter int unsigned ADDR_W  = fir_seq_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] ptr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(Q_DEPTH - 1);

  // Pointer register; load has priority over increment
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= load_val;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fir_seq_ctrl.sv
// Sequencer for the shared FIR band-filter datapath.
// On each accepted sample it clears the accumulators, walks the full coefficient
// window over the queue, and flags when the filter sums are ready.
// Optional feature: define FIR_SEQ_OVR_EN to build the sticky overrun flag;
// otherwise overrun is tied low.
module fir_seq_ctrl #(
  parameter int unsigned NUM_TAPS = fir_seq_pkg::NUM_TAPS,
  parameter int unsigned Q_DEPTH  = fir_seq_pkg::Q_DEPTH,
  parameter int unsigned ADDR_W   = fir_seq_pkg::ADDR_W,
  parameter int unsigned COEF_W   = fir_seq_pkg::COEF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              smpl_vld,
  input  logic [ADDR_W-1:0] new_ptr,
  output logic              sequencing,
  output logic              accum_clr,
  output logic              mac_en,
  output logic [COEF_W-1:0] coef_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              res_vld,
  output logic              busy,
  output logic              overrun
);

  import fir_seq_pkg::*;

  localparam int unsigned FILL_W  = $clog2(NUM_TAPS + 1);
  localparam int unsigned FILL_XW = FILL_W + 1;
  localparam int unsigned EXT_W   = ADDR_W + 1;
  localparam int unsigned SPAN    = NUM_TAPS - 1;

  localparam logic [COEF_W-1:0] COEF_LAST = COEF_W'(NUM_TAPS - 1);

  state_t              state;
  state_t              state_nxt;
  logic [FILL_W-1:0]   fill_cnt;
  logic [FILL_W-1:0]   fill_nxt;
  logic [FILL_XW-1:0]  fill_inc_c;
  logic [COEF_W-1:0]   coef_nxt;
  logic                seq_nxt;
  logic                clr_nxt;
  logic                res_nxt;
  logic                busy_nxt;
  logic                load_c;
  logic                inc_c;
  logic [EXT_W-1:0]    ptr_ext_c;
  logic [ADDR_W-1:0]   start_ptr_c;

  // Oldest sample of the window ending at new_ptr, modulo the queue depth
  always_comb begin
    ptr_ext_c   = EXT_W'(new_ptr);
    start_ptr_c = '0;
    if (ptr_ext_c >= EXT_W'(SPAN)) begin
      start_ptr_c = ADDR_W'(ptr_ext_c - EXT_W'(SPAN));
    end else begin
      start_ptr_c = ADDR_W'(ptr_ext_c + EXT_W'(Q_DEPTH) - EXT_W'(SPAN));
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, fill count, coefficient walk and next-cycle output values
  always_comb begin
    state_nxt  = state;
    fill_nxt   = fill_cnt;
    coef_nxt   = coef_addr;
    load_c     = 1'b0;
    inc_c      = 1'b0;
    fill_inc_c = FILL_XW'(fill_cnt) + FILL_XW'(1);

    case (state)
      IDLE: begin
        if (smpl_vld) begin
          if (fill_inc_c < FILL_XW'(NUM_TAPS)) begin
            fill_nxt = fill_cnt + FILL_W'(1);
          end else begin
            fill_nxt  = FILL_W'(NUM_TAPS);
            load_c    = 1'b1;
            coef_nxt  = '0;
            state_nxt = CLR;
          end
        end
      end
      CLR: begin
        state_nxt = RUN;
      end
      RUN: begin
        if (coef_addr == COEF_LAST) begin
          state_nxt = DRAIN;
        end else begin
          coef_nxt = coef_addr + COEF_W'(1);
          inc_c    = 1'b1;
        end
      end
      DRAIN: begin
        state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    seq_nxt  = (state_nxt == RUN);
    clr_nxt  = (state_nxt == CLR);
    res_nxt  = (state_nxt == DONE);
    busy_nxt = (state_nxt != IDLE);
  end

  // Registered outputs; mac_en trails sequencing by one cycle for the ROM/queue read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt   <= '0;
      coef_addr  <= '0;
      sequencing <= 1'b0;
      accum_clr  <= 1'b0;
      mac_en     <= 1'b0;
      res_vld    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      fill_cnt   <= fill_nxt;
      coef_addr  <= coef_nxt;
      sequencing <= seq_nxt;
      accum_clr  <= clr_nxt;
      mac_en     <= sequencing;
      res_vld    <= res_nxt;
      busy       <= busy_nxt;
    end
  end

  // Queue read address walks with the coefficient index
  fir_rd_ptr #(
    .Q_DEPTH (Q_DEPTH),
    .ADDR_W  (ADDR_W)
  ) u_rd_ptr (
    .clk      (clk),
    .rst      (rst),
    .load     (load_c),
    .inc      (inc_c),
    .load_val (start_ptr_c),
    .ptr      (rd_addr)
  );

`ifdef FIR_SEQ_OVR_EN
  // Sticky flag: a sample arrived while a window was still in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (smpl_vld && (state != IDLE)) begin
      overrun <= 1'b1;
    end
  end
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Self-checking bench for fir_seq_ctrl against a cycle-offset reference model.
module tb_fir_seq_ctrl;

  localparam int N  = 1021;
  localparam int Q  = 1536;
  localparam int AW = 11;
  localparam int CW = 10;
  localparam int VW = 6 + CW + AW;

`ifdef FIR_SEQ_OVR_EN
  localparam bit OVR_BUILT = 1'b1;
`else
  localparam bit OVR_BUILT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          smpl_vld;
  logic [AW-1:0] new_ptr;
  logic          sequencing;
  logic          accum_clr;
  logic          mac_en;
  logic [CW-1:0] coef_addr;
  logic [AW-1:0] rd_addr;
  logic          res_vld;
  logic          busy;
  logic          overrun;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  int fill_m;
  bit ovr_m;
  int last_coef;
  int last_rd;

  // per-window observations
  int w_first_rd, w_end_rd, w_mac_cnt, w_mac_first, w_res_cnt, w_res_d;
  int w_seq_cnt, w_clr_d;
  bit w_wrap;

  always #5 clk = ~clk;

  fir_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .smpl_vld   (smpl_vld),
    .new_ptr    (new_ptr),
    .sequencing (sequencing),
    .accum_clr  (accum_clr),
    .mac_en     (mac_en),
    .coef_addr  (coef_addr),
    .rd_addr    (rd_addr),
    .res_vld    (res_vld),
    .busy       (busy),
    .overrun    (overrun)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [VW-1:0] obs_vec();
    return {busy, sequencing, accum_clr, mac_en, res_vld, overrun, coef_addr, rd_addr};
  endfunction

  // Expected outputs d cycles after a sample is accepted at d=0
  function automatic logic [VW-1:0] exp_vec(input int d, input int start, input int ptr);
    logic [5:0] f;
    int c;
    int r;
    f = {(d >= 1 && d <= N + 3), (d >= 2 && d <= N + 1), (d == 1),
         (d >= 3 && d <= N + 2), (d == N + 3), ovr_m};
    if (d == 0) begin
      c = last_coef; r = last_rd;
    end else if (d == 1) begin
      c = 0; r = start;
    end else if (d <= N + 1) begin
      c = d - 2; r = (start + d - 2) % Q;
    end else begin
      c = N - 1; r = ptr;
    end
    return {f, CW'(c), AW'(r)};
  endfunction

  // Accept one sample at ptr and follow the whole window cycle by cycle
  task automatic run_window(input int ptr, input int inj_d, input int rst_d, input string tag);
    int start;
    int prev_rd;
    logic [VW-1:0] e;
    logic [VW-1:0] o;
    start = (ptr + Q - (N - 1)) % Q;
    w_first_rd = -1; w_end_rd = -1; w_mac_cnt = 0; w_mac_first = -1;
    w_res_cnt = 0; w_res_d = -1; w_seq_cnt = 0; w_clr_d = -1; w_wrap = 1'b0;
    prev_rd = -1;
    e = exp_vec(0, start, ptr);
    o = obs_vec();
    n_chk++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL %s d=0 got=%h exp=%h", tag, o, e);
    end
    smpl_vld = 1'b1;
    new_ptr  = AW'(ptr);
    fill_m   = N;
    @(posedge clk); #1;
    smpl_vld = 1'b0;
    for (int d = 1; d <= N + 3; d++) begin
      e = exp_vec(d, start, ptr);
      o = obs_vec();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s d=%0d got=%h exp=%h", tag, d, o, e);
      end
      if (d == 1) w_first_rd = int'(rd_addr);
      if (d == N + 2) w_end_rd = int'(rd_addr);
      if (prev_rd == Q - 1 && rd_addr == '0) w_wrap = 1'b1;
      prev_rd = int'(rd_addr);
      if (mac_en) begin
        w_mac_cnt++;
        if (w_mac_first < 0) w_mac_first = d;
      end
      if (sequencing) w_seq_cnt++;
      if (accum_clr) w_clr_d = d;
      if (res_vld) begin
        w_res_cnt++;
        w_res_d = d;
      end
      smpl_vld = (d == inj_d);
      new_ptr  = AW'($urandom_range(0, Q - 1));
      rst      = (d == rst_d);
      if (d == inj_d) ovr_m = ovr_m | OVR_BUILT;
      @(posedge clk); #1;
      smpl_vld = 1'b0;
      if (d == rst_d) begin
        rst = 1'b0;
        o = obs_vec();
        n_chk++;
        if (o !== '0) begin
          n_fail++;
          $display("FAIL %s reset_mid_run got=%h exp=0", tag, o);
        end
        fill_m = 0; ovr_m = 1'b0; last_coef = 0; last_rd = 0;
        return;
      end
    end
    last_coef = N - 1;
    last_rd   = ptr;
  endtask

  task automatic test_reset();
    logic [VW-1:0] o;
    rst = 1'b1; smpl_vld = 1'b1; new_ptr = '0;
    repeat (3) @(posedge clk);
    #1;
    o = obs_vec();
    n_chk++;
    if (o !== '0) begin
      n_fail++;
      $display("FAIL reset_hold got=%h exp=0", o);
    end
    rst = 1'b0; smpl_vld = 1'b0;
    @(posedge clk); #1;
    o = obs_vec();
    n_chk++;
    if (o !== '0) begin
      n_fail++;
      $display("FAIL reset_release got=%h exp=0", o);
    end
    fill_m = 0; ovr_m = 1'b0; last_coef = 0; last_rd = 0;
  endtask

  // N-1 samples must only fill; the next one opens a window
  task automatic test_fill(input string tag);
    logic [VW-1:0] e;
    logic [VW-1:0] o;
    for (int i = 0; i < N - 1; i++) begin
      e = {5'b0, ovr_m, CW'(last_coef), AW'(last_rd)};
      o = obs_vec();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s fill=%0d got=%h exp=%h", tag, fill_m, o, e);
      end
      smpl_vld = 1'b1;
      new_ptr  = AW'($urandom_range(0, Q - 1));
      @(posedge clk); #1;
      fill_m++;
    end
    smpl_vld = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (busy !== 1'b0 || sequencing !== 1'b0 || accum_clr !== 1'b0) begin
      n_fail++;
      $display("FAIL %s primed_idle busy=%b seq=%b clr=%b exp=0", tag, busy, sequencing, accum_clr);
    end
  endtask

  task automatic test_priming();
    test_fill("priming");
    run_window(5, -1, -1, "prime_p5");
    n_chk++;
    if (w_first_rd !== 521 || w_end_rd !== 5 || w_wrap !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_p5 start=%0d end=%0d wrap=%0d exp 521/5/1", w_first_rd, w_end_rd, w_wrap);
    end
    n_chk++;
    if (w_clr_d !== 1 || w_seq_cnt !== 1021) begin
      n_fail++;
      $display("FAIL prime_seq clr_d=%0d seq_cnt=%0d exp 1/1021", w_clr_d, w_seq_cnt);
    end
    n_chk++;
    if (w_mac_cnt !== 1021 || w_mac_first !== 3) begin
      n_fail++;
      $display("FAIL latency_mac cnt=%0d first=%0d exp 1021/3", w_mac_cnt, w_mac_first);
    end
    n_chk++;
    if (w_res_cnt !== 1 || w_res_d !== 1024) begin
      n_fail++;
      $display("FAIL latency_res cnt=%0d at=%0d exp 1/1024", w_res_cnt, w_res_d);
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_drop got=%b exp=0", busy);
    end
  endtask

  task automatic test_window_wrap();
    repeat (3) @(posedge clk);
    #1;
    run_window(1100, -1, -1, "win_p1100");
    n_chk++;
    if (w_first_rd !== 80 || w_end_rd !== 1100 || w_wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_p1100 start=%0d end=%0d wrap=%0d exp 80/1100/0", w_first_rd, w_end_rd, w_wrap);
    end
    run_window(1020, -1, -1, "win_p1020");
    n_chk++;
    if (w_first_rd !== 0 || w_end_rd !== 1020) begin
      n_fail++;
      $display("FAIL edge_p1020 start=%0d end=%0d exp 0/1020", w_first_rd, w_end_rd);
    end
  endtask

  task automatic test_back_to_back();
    run_window(int'($urandom_range(0, Q - 1)), -1, -1, "b2b_a");
    run_window(int'($urandom_range(0, Q - 1)), -1, -1, "b2b_b");
    n_chk++;
    if (w_res_cnt !== 1 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b res_cnt=%0d overrun=%b exp 1/0", w_res_cnt, overrun);
    end
  endtask

  task automatic test_random();
    logic [VW-1:0] e;
    logic [VW-1:0] o;
    int gap;
    for (int k = 0; k < 3; k++) begin
      gap = int'($urandom_range(0, 5));
      for (int g = 0; g < gap; g++) begin
        e = {5'b0, ovr_m, CW'(last_coef), AW'(last_rd)};
        o = obs_vec();
        n_chk++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL rand_gap k=%0d got=%h exp=%h", k, o, e);
        end
        @(posedge clk); #1;
      end
      run_window(int'($urandom_range(0, Q - 1)), -1, -1, "rand_win");
    end
  endtask

  task automatic test_overrun();
    logic [VW-1:0] e;
    logic [VW-1:0] o;
    for (int s = 0; s < 2; s++) begin
      run_window(int'($urandom_range(0, Q - 1)), (s == 0) ? 502 : N + 3, -1,
                 (s == 0) ? "ovr_run" : "ovr_done");
      for (int g = 0; g < 4; g++) begin
        e = {5'b0, ovr_m, CW'(last_coef), AW'(last_rd)};
        o = obs_vec();
        n_chk++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL ovr_no_restart s=%0d g=%0d got=%h exp=%h", s, g, o, e);
        end
        @(posedge clk); #1;
      end
      n_chk++;
      if (overrun !== OVR_BUILT) begin
        n_fail++;
        $display("FAIL ovr_flag s=%0d got=%b exp=%b", s, overrun, OVR_BUILT);
      end
    end
    run_window(int'($urandom_range(0, Q - 1)), -1, -1, "ovr_sticky");
  endtask

  task automatic test_reset_mid_run();
    run_window(int'($urandom_range(0, Q - 1)), -1, 502, "rst_mid");
    test_fill("refill");
    run_window(int'($urandom_range(0, Q - 1)), -1, -1, "refill_win");
    n_chk++;
    if (w_res_d !== 1024 || w_mac_cnt !== 1021) begin
      n_fail++;
      $display("FAIL refill_latency res_at=%0d mac_cnt=%0d exp 1024/1021", w_res_d, w_mac_cnt);
    end
  endtask

  initial begin
    rst = 1'b1; smpl_vld = 1'b0; new_ptr = '0;
    fill_m = 0; ovr_m = 1'b0; last_coef = 0; last_rd = 0;
    test_reset();
    test_priming();
    test_window_wrap();
    test_back_to_back();
    test_random();
    test_overrun();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_seq_ctrl.md
# fir_seq_ctrl

Sequencer for the shared FIR band-filter datapath of the equalizer. On each new audio sample written to the circular sample queue, it steps the filters through the full coefficient window. It drives the coefficient ROM address, the queue read address, the accumulator clear and MAC enables, and flags when the filter outputs are valid to capture. It sits between the sample queue and the band filters (LP/B1/B2/B3/HP), which all share its control outputs.

## Interface
- NUM_TAPS, 1021: coefficients per filter, which is also the MAC cycles per sample.
- Q_DEPTH, 1536: circular sample queue depth.
- ADDR_W, 11: width of the queue read address. It must satisfy 2^ADDR_W >= Q_DEPTH.
- COEF_W, 10: width of the coefficient address. It must satisfy 2^COEF_W >= NUM_TAPS.
- clk, input, 1: single system clock. All logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- smpl_vld, input, 1: one-cycle pulse when the queue has written a new sample.
- new_ptr, input, ADDR_W: queue index of the newest sample. It is valid with smpl_vld.
- sequencing, output, 1: high for the whole RUN window. It goes to the filters' sequencing inputs.
- accum_clr, output, 1: one-cycle accumulator clear, issued before RUN.
- mac_en, output, 1: accumulate enable for the filters. It is delayed to match the one-cycle ROM and queue read latency.
- coef_addr, output, COEF_W: coefficient ROM address.
- rd_addr, output, ADDR_W: queue read address.
- res_vld, output, 1: one-cycle pulse when the filter accumulators hold the final sum.
- busy, output, 1: high in every state except IDLE.
- overrun, output, 1: sticky flag, set when a sample arrives while busy.

## Operation
- Reset values: all outputs are 0, the FSM is in IDLE and fill_cnt is 0.
- fill_cnt:
  - It counts accepted smpl_vld pulses and saturates at NUM_TAPS.
  - It prevents filtering before the queue holds a full window.
- FSM states: IDLE, CLR, RUN, DRAIN, DONE.
- IDLE:
  - On smpl_vld with fill_cnt+1 < NUM_TAPS: increment fill_cnt and stay in IDLE.
  - On smpl_vld with fill_cnt+1 >= NUM_TAPS: latch the start pointer and go to CLR.
  - Start pointer = new_ptr - (NUM_TAPS-1), taken mod Q_DEPTH. If new_ptr < NUM_TAPS-1, add Q_DEPTH before subtracting.
- CLR (1 cycle):
  - accum_clr=1.
  - rd_addr is set to the start pointer and coef_addr to 0.
  - Next state is RUN.
- RUN (NUM_TAPS cycles):
  - sequencing=1.
  - coef_addr increments by 1 each cycle, from 0 to NUM_TAPS-1.
  - rd_addr increments each cycle and wraps from Q_DEPTH-1 to 0.
  - The cycle with coef_addr = NUM_TAPS-1 is the last RUN cycle; next state is DRAIN.
- DRAIN (1 cycle): sequencing=0. mac_en stays high for this cycle to cover the final ROM read.
- DONE (1 cycle): res_vld=1, then back to IDLE.
- mac_en equals sequencing delayed by one cycle.
- coef_addr and rd_addr hold their last values outside RUN.
- smpl_vld while busy:
  - The sample is not sequenced and is not queued.
  - overrun is set, when the feature is compiled in.
- Simultaneous events:
  - rst wins over everything.
  - smpl_vld in the DONE cycle counts as an overrun.
- rst mid-operation: the FSM returns to IDLE and fill_cnt clears, so a full refill is required.

## Timing
- smpl_vld accepted at cycle 0:
  - Cycle 1: CLR.
  - Cycles 2 to NUM_TAPS+1: RUN.
  - Cycle NUM_TAPS+2: DRAIN.
  - Cycle NUM_TAPS+3: DONE.
- mac_en is high in cycles 3 to NUM_TAPS+2, i.e. exactly NUM_TAPS cycles.
- res_vld is high only in cycle NUM_TAPS+3.
- busy is high in cycles 1 to NUM_TAPS+3. The earliest next acceptance is cycle NUM_TAPS+4.
- All outputs are registered, with no combinational path from input to output.

## Configuration
- FIR_SEQ_OVR_EN defined:
  - The overrun sticky register is built.
  - It sets on smpl_vld while busy and clears only on rst.
- FIR_SEQ_OVR_EN undefined:
  - No overrun logic is built and the overrun port is tied 0.
  - The port list is unchanged.

## Structure
- Shared package fir_seq_pkg holds:
  - the state enum type (IDLE, CLR, RUN, DRAIN, DONE);
  - the default constants NUM_TAPS, Q_DEPTH, ADDR_W and COEF_W.
- One sub-module, fir_rd_ptr: a modular read-pointer counter with load, increment and Q_DEPTH wrap. It is used for rd_addr.
- The FSM, fill_cnt, coef_addr and the mac_en delay live in fir_seq_ctrl.

## Test plan
All scenarios use the default parameters.
- Priming: 1020 smpl_vld pulses leave the block in IDLE with busy=0. The 1021st pulse gives accum_clr one cycle later, then sequencing high for exactly 1021 cycles.
- Window and wrap: new_ptr=5 gives start rd_addr=521. rd_addr reaches 1535, wraps to 0 and ends at 5. new_ptr=1100 gives a start of 80 and an end of 1100.
- Latency: mac_en is high exactly 1021 cycles, starting 3 cycles after acceptance. res_vld pulses once, 1024 cycles after acceptance. busy then drops.
- Overrun: smpl_vld during RUN (and separately during DONE) sets overrun=1. No second window is started. overrun stays 1 until rst.
- Reset mid-RUN: rst at RUN cycle 500 gives all outputs 0 on the next cycle. A following smpl_vld does not start a window until 1021 new samples have arrived.
- Back-to-back: smpl_vld in the first IDLE cycle after DONE is accepted with no overrun. In the build without FIR_SEQ_OVR_EN, overrun stays 0 throughout all scenarios.
